// File: rtl/rv_pkg.sv
// Shared register-file constants and sequencer state type.
// Reused by the core datapath, so keep it free of sequencer-only details.
package rv_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int PAW   = AW - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DUMP,
    DONE
  } state_e;

  // A register pair p covers x(2p) on read port 1 and x(2p+1) on read port 2.
  function automatic logic [AW-1:0] pair_even(input logic [PAW-1:0] pair);
    return {pair, 1'b0};
  endfunction

  function automatic logic [AW-1:0] pair_odd(input logic [PAW-1:0] pair);
    return {pair, 1'b1};
  endfunction

endpackage

// File: rtl/rf_access_sequencer_if.sv
// Bus bundle between the register-file access sequencer and its environment:
// control, load stream, dump stream and the register-file ports.
interface rf_access_sequencer_if;
  import rv_pkg::*;

  logic              load_start;
  logic              dump_start;
  logic              busy;
  logic              done;

  logic [XLEN-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;

  logic [2*XLEN-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  logic [XLEN-1:0]   rf_write_data;
  logic [AW-1:0]     rf_rd;
  logic              rf_reg_write;
  logic [AW-1:0]     rf_rs1;
  logic [AW-1:0]     rf_rs2;
  logic [XLEN-1:0]   rf_read_data1;
  logic [XLEN-1:0]   rf_read_data2;

  modport master (
    input  load_start, dump_start,
    output busy, done,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready,
    output rf_write_data, rf_rd, rf_reg_write, rf_rs1, rf_rs2,
    input  rf_read_data1, rf_read_data2
  );

  modport slave (
    output load_start, dump_start,
    input  busy, done,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready,
    input  rf_write_data, rf_rd, rf_reg_write, rf_rs1, rf_rs2,
    output rf_read_data1, rf_read_data2
  );

endinterface

// File: rtl/rf_access_sequencer.sv
// Register-file access sequencer: LOAD streams words into x1..x31 through the
// write port, DUMP streams register pairs out through both read ports.
module rf_access_sequencer
  import rv_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  rf_access_sequencer_if.master bus
);

  state_e          state_q, state_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic [PAW-1:0]  pidx_q, pidx_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;

  logic load_acc;
  logic dump_acc;
  logic load_last;
  logic dump_last;

  assign load_acc  = (state_q == LOAD) && bus.in_valid;
  assign dump_acc  = (state_q == DUMP) && bus.out_ready;
  assign load_last = (widx_q == AW'(NREGS - 1));
  assign dump_last = (pidx_q == PAW'(NREGS / 2 - 1));

  // NOTE: sequential state uses non-blocking assignments and a synchronous,
  // active-high reset sampled only at the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD;
        end else if (bus.dump_start) begin
          state_d = DUMP;
        end
      end
      LOAD:    if (load_acc && load_last) state_d = DONE;
      DUMP:    if (dump_acc && dump_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.in_ready  = (state_q == LOAD);
    bus.out_valid = (state_q == DUMP);
  end

  // Counters, the one-deep write stage and the registered read addresses.
  always_comb begin
    widx_d    = widx_q;
    pidx_d    = pidx_q;
    wr_en_d   = load_acc;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;

    if (state_q == IDLE) begin
      if (bus.load_start) begin
        widx_d = AW'(1);
      end else if (bus.dump_start) begin
        pidx_d = '0;
        rs1_d  = pair_even('0);
        rs2_d  = pair_odd('0);
      end
    end

    if (load_acc) begin
      wr_addr_d = widx_q;
      wr_data_d = bus.in_data;
      if (!load_last) begin
        widx_d = widx_q + AW'(1);
      end
    end

    // Addresses only move on a handshake, so a stalled beat stays stable.
    if (dump_acc && !dump_last) begin
      pidx_d = pidx_q + PAW'(1);
      rs1_d  = pair_even(pidx_q + PAW'(1));
      rs2_d  = pair_odd(pidx_q + PAW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      widx_q    <= '0;
      pidx_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      widx_q    <= widx_d;
      pidx_q    <= pidx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  // A write pending from the accept before reset must not commit in the reset cycle.
  assign bus.rf_reg_write  = wr_en_q && !reset;
  assign bus.rf_rd         = wr_addr_q;
  assign bus.rf_write_data = wr_data_q;
  assign bus.rf_rs1        = rs1_q;
  assign bus.rf_rs2        = rs2_q;
  assign bus.out_data      = {bus.rf_read_data2, bus.rf_read_data1};

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Self-checking bench: a transaction-level model (accept count, beat count,
// expected register contents) checks every DUT output on every cycle.
module tb_rf_access_sequencer;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_access_sequencer_if bus ();

  rf_access_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Register file seen by the DUT; a preload path stands in for the core.
  logic [XLEN-1:0] rf_mem   [NREGS];
  logic [XLEN-1:0] pre_vals [NREGS];
  logic            pre_go = 1'b0;

  always @(posedge clk) begin
    if (pre_go) begin
      for (int i = 0; i < NREGS; i++) rf_mem[i] <= pre_vals[i];
    end else if (bus.rf_reg_write) begin
      rf_mem[bus.rf_rd] <= bus.rf_write_data;
    end
  end

  assign bus.rf_read_data1 = (bus.rf_rs1 == '0) ? '0 : rf_mem[bus.rf_rs1];
  assign bus.rf_read_data2 = (bus.rf_rs2 == '0) ? '0 : rf_mem[bus.rf_rs2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: which phase we are in, how many words/beats have gone,
  // the write due this cycle, and what the register file must contain.
  typedef enum {M_IDLE, M_LOAD, M_DUMP, M_FIN} mode_e;
  mode_e             mode      = M_IDLE;
  int                nacc      = 0;
  int                nbeat     = 0;
  bit                pend      = 1'b0;
  int                pend_rd   = 0;
  logic [XLEN-1:0]   pend_data = '0;
  logic [XLEN-1:0]   ref_rf [NREGS];
  logic [2*XLEN-1:0] beats [$];
  int                nwrites   = 0;
  int                run       = 0;
  int                max_run   = 0;
  int                done_seen = 0;

  always @(negedge clk) begin
    if (pre_go) begin
      for (int i = 0; i < NREGS; i++) ref_rf[i] = pre_vals[i];
    end
    if (reset) begin
      check("write_in_reset", bus.rf_reg_write, 1'b0);
      mode = M_IDLE;
      pend = 1'b0;
      run  = 0;
    end else begin
      check("ctrl", {bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.rf_reg_write},
            {mode != M_IDLE, mode == M_FIN, mode == M_LOAD, mode == M_DUMP, pend});
      if (pend) begin
        check("write", {bus.rf_rd, bus.rf_write_data}, {AW'(pend_rd), pend_data});
        ref_rf[pend_rd] = pend_data;
        nwrites++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (mode == M_DUMP) begin
        check("beat", bus.out_data, {ref_rf[2*nbeat+1], ref_rf[2*nbeat]});
      end
      pend = 1'b0;
      case (mode)
        M_IDLE: begin
          if (bus.load_start) begin
            mode = M_LOAD;
            nacc = 0;
          end else if (bus.dump_start) begin
            mode  = M_DUMP;
            nbeat = 0;
            beats.delete();
          end
        end
        M_LOAD: begin
          if (bus.in_valid) begin
            nacc++;
            pend      = 1'b1;
            pend_rd   = nacc;
            pend_data = bus.in_data;
            if (nacc == NREGS - 1) mode = M_FIN;
          end
        end
        M_DUMP: begin
          if (bus.out_ready) begin
            beats.push_back(bus.out_data);
            nbeat++;
            if (nbeat == NREGS / 2) mode = M_FIN;
          end
        end
        default: begin
          done_seen++;
          mode = M_IDLE;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int kind);
    pre_vals[0] = '0;
    for (int k = 1; k < NREGS; k++) begin
      case (kind)
        0:       pre_vals[k] = '0;
        1:       pre_vals[k] = XLEN'(k);
        2:       pre_vals[k] = 64'hA5A5_0000 + XLEN'(k);
        default: pre_vals[k] = {$urandom, $urandom};
      endcase
    end
    pre_go = 1'b1;
    tick();
    pre_go = 1'b0;
  endtask

  // vmode: 0 = in_valid held high, 1 = every third cycle, 2 = random.
  task automatic run_load(input int vmode, input bit ramp, input bit both);
    int acc = 0;
    int cyc = 0;
    bus.load_start = 1'b1;
    bus.dump_start = both;
    tick();
    bus.load_start = 1'b0;
    while (acc < NREGS - 1 && cyc < 2000) begin
      bus.in_valid   = (vmode == 0) || (vmode == 1 && cyc % 3 == 2) ||
                       (vmode == 2 && $urandom_range(1, 0) == 1);
      bus.in_data    = ramp ? 64'h1111 * XLEN'(acc + 1) : {$urandom, $urandom};
      bus.dump_start = ($urandom_range(3, 0) == 0);
      bus.load_start = ($urandom_range(3, 0) == 0);
      tick();
      if (bus.in_valid) acc++;
      cyc++;
    end
    check("load_budget", cyc < 2000, 1'b1);
    bus.in_valid   = 1'b0;
    bus.dump_start = 1'b0;
    bus.load_start = 1'b0;
    tick();
  endtask

  // rmode: 0 = out_ready held high, 1 = pattern 1,0,0,1, 2 = random.
  task automatic run_dump(input int rmode);
    int nb  = 0;
    int cyc = 0;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    while (nb < NREGS / 2 && cyc < 2000) begin
      bus.out_ready  = (rmode == 0) || (rmode == 1 && (cyc % 4 == 0 || cyc % 4 == 3)) ||
                       (rmode == 2 && $urandom_range(1, 0) == 1);
      bus.load_start = ($urandom_range(3, 0) == 0);
      bus.dump_start = ($urandom_range(3, 0) == 0);
      tick();
      if (bus.out_ready) nb++;
      cyc++;
    end
    check("dump_budget", cyc < 2000, 1'b1);
    bus.out_ready  = 1'b0;
    bus.load_start = 1'b0;
    bus.dump_start = 1'b0;
    tick();
  endtask

  initial begin
    int w0;
    int d0;
    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.dump_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    preload(0);
    repeat (2) tick();
    check("reset_ctrl", {bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.rf_reg_write}, 5'b0);
    check("reset_addr", {bus.rf_rd, bus.rf_rs1, bus.rf_rs2, bus.rf_write_data}, '0);
    reset = 1'b0;
    tick();

    // Load ramp, then dump straight after done.
    d0 = done_seen;
    run_load(0, 1'b1, 1'b0);
    check("ramp_run", max_run, 31);
    check("ramp_done", done_seen - d0, 1);
    run_dump(0);
    check("ramp_beats", beats.size(), 16);
    check("ramp_beat0", beats[0], {64'h1111, 64'h0});
    check("ramp_beat15", beats[15], {64'h2_110F, 64'h1_FFFE});

    // Dump under backpressure.
    preload(1);
    run_dump(1);
    check("bp_beats", beats.size(), 16);
    for (int p = 0; p < 16; p++) begin
      check("bp_beat", beats[p], {XLEN'(2*p + 1), XLEN'(2*p)});
    end

    // Sparse load.
    w0 = nwrites;
    d0 = done_seen;
    run_load(1, 1'b0, 1'b0);
    check("sparse_writes", nwrites - w0, 31);
    check("sparse_done", done_seen - d0, 1);

    // Simultaneous start: load wins.
    w0 = nwrites;
    run_load(0, 1'b0, 1'b1);
    check("both_writes", nwrites - w0, 31);

    // Reset mid-LOAD after ten words have been written.
    preload(2);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      bus.in_data = 64'hC0DE_0000 + XLEN'(k);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_load_ctrl", {bus.busy, bus.in_ready, bus.rf_reg_write}, 3'b000);
    tick();
    bus.in_valid = 1'b0;
    check("abort_x10", rf_mem[10], 64'hC0DE_000A);
    check("abort_x11", rf_mem[11], 64'hA5A5_000B);
    check("abort_x31", rf_mem[31], 64'hA5A5_001F);
    run_dump(0);

    // Reset mid-DUMP at beat 5 under a stall.
    preload(1);
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (5) tick();
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("stall_beat5", bus.out_data, {64'd11, 64'd10});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_dump_ctrl", {bus.busy, bus.out_valid}, 2'b00);
    tick();
    run_dump(0);
    check("restart_beat0", beats[0], {64'd1, 64'd0});

    // Randomized traffic.
    for (int it = 0; it < 6; it++) begin
      preload(3);
      run_load(2, 1'b0, $urandom_range(1, 0) == 1);
      run_dump(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
